// File: rtl/wb_arbiter_if.sv
// Writeback-stage bus: ALU/long-latency results in, scoreboard queries,
// and the registered register-file write port out.
interface wb_arbiter_if #(
  parameter int REG_ADDR_W = 5,
  parameter int REG_DATA_W = 32
);
  logic                  alu_valid_i;
  logic [REG_ADDR_W-1:0] alu_rd_i;
  logic [REG_DATA_W-1:0] alu_data_i;

  // lsu handshake: a result transfers at a rising edge where lsu_valid_i and
  // lsu_ready_o are both 1; the producer holds rd/data stable until then.
  logic                  lsu_valid_i;
  logic                  lsu_ready_o;
  logic [REG_ADDR_W-1:0] lsu_rd_i;
  logic [REG_DATA_W-1:0] lsu_data_i;

  logic                  issue_en_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic [REG_ADDR_W-1:0] chk_addr1_i;
  logic [REG_ADDR_W-1:0] chk_addr2_i;
  logic                  busy1_o;
  logic                  busy2_o;
  logic                  wb_stall_o;

  logic                  w_en_o;
  logic [REG_ADDR_W-1:0] w_addr_o;
  logic [REG_DATA_W-1:0] w_data_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output issue_en_i, issue_rd_i, chk_addr1_i, chk_addr2_i,
    input  lsu_ready_o, busy1_o, busy2_o, wb_stall_o,
    input  w_en_o, w_addr_o, w_data_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  issue_en_i, issue_rd_i, chk_addr1_i, chk_addr2_i,
    output lsu_ready_o, busy1_o, busy2_o, wb_stall_o,
    output w_en_o, w_addr_o, w_data_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win, long-latency results queue in a FIFO,
// a starvation counter forces a FIFO drain, and a pending scoreboard feeds decode.
module wb_arbiter #(
  parameter int REG_NUM      = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int REG_DATA_W   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] LAST_C   = PTR_W'(FIFO_DEPTH - 1);

  logic [REG_ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
  logic [REG_DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count, count_n;
  logic [REG_NUM-1:0]    pending, pending_n;
  logic [STV_W-1:0]      starve_cnt, starve_n;
  logic                  stall_q, stall_n;
  logic                  w_en_q;
  logic [REG_ADDR_W-1:0] w_addr_q;
  logic [REG_DATA_W-1:0] w_data_q;

  logic                  fifo_empty, lsu_ready, push, pop, alu_win;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [REG_DATA_W-1:0] head_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Ready comes from the registered count only, so a full FIFO never accepts
  // in the same cycle it pops.
  assign fifo_empty = (count == '0);
  assign lsu_ready  = !rst && (count < DEPTH_C);
  assign push       = bus.lsu_valid_i && lsu_ready;
  assign head_rd    = fifo_rd[head];
  assign head_data  = fifo_data[head];

  assign alu_win = !stall_q && bus.alu_valid_i && (bus.alu_rd_i != '0);
  assign pop     = !alu_win && !fifo_empty;
  assign count_n = count + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    pending_n = pending;
    if (pop) pending_n[head_rd] = 1'b0;
    // An issue in the same cycle as the matching pop belongs to a newer op.
    if (bus.issue_en_i) pending_n[bus.issue_rd_i] = 1'b1;
    pending_n[0] = 1'b0;
  end

  always_comb begin
    starve_n = starve_cnt;
    if (pop || fifo_empty) starve_n = '0;
    else if (alu_win)      starve_n = starve_cnt + 1'b1;
    stall_n = (starve_n == STARVE_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      pending    <= '0;
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      count      <= count_n;
      pending    <= pending_n;
      starve_cnt <= starve_n;
      stall_q    <= stall_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= bus.lsu_rd_i;
      fifo_data[tail] <= bus.lsu_data_i;
    end
  end

  // Entries for x0 are popped silently; address and data hold their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else if (alu_win) begin
      w_en_q   <= 1'b1;
      w_addr_q <= bus.alu_rd_i;
      w_data_q <= bus.alu_data_i;
    end else if (pop && (head_rd != '0)) begin
      w_en_q   <= 1'b1;
      w_addr_q <= head_rd;
      w_data_q <= head_data;
    end else begin
      w_en_q   <= 1'b0;
    end
  end

  assign bus.lsu_ready_o = lsu_ready;
  assign bus.busy1_o     = pending[bus.chk_addr1_i];
  assign bus.busy2_o     = pending[bus.chk_addr2_i];
  assign bus.wb_stall_o  = stall_q;
  assign bus.w_en_o      = w_en_q;
  assign bus.w_addr_o    = w_addr_q;
  assign bus.w_data_o    = w_data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected regfile writes are queued when the
// stimulus is driven and matched against w_en_o/w_addr_o/w_data_o.
module tb_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.REG_ADDR_W(AW), .REG_DATA_W(DW)) bus ();

  wb_arbiter #(
    .REG_NUM(32), .REG_ADDR_W(AW), .REG_DATA_W(DW),
    .FIFO_DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [AW+DW-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic exp_write(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Scoreboard: every write on the port must be the oldest expected one.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (!rst && bus.w_en_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", bus.w_en_o, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("wb_addr", bus.w_addr_o, e[AW+DW-1:DW]);
        check("wb_data", bus.w_data_o, e[DW-1:0]);
      end
    end
  end

  // Upstream contract: no ALU result while the stage is stalled.
  always @(posedge clk) begin
    if (!rst && bus.wb_stall_o) check("alu_while_stall", bus.alu_valid_i, 1'b0);
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] da, db, dc;

    rst = 1'b1;
    bus.alu_valid_i = 1'b0; bus.alu_rd_i = '0; bus.alu_data_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = '0; bus.lsu_data_i = '0;
    bus.issue_en_i  = 1'b0; bus.issue_rd_i = '0;
    bus.chk_addr1_i = '0;   bus.chk_addr2_i = '0;
    repeat (2) @(negedge clk);

    check("rst_w_en",  bus.w_en_o,      1'b0);
    check("rst_w_addr", bus.w_addr_o,   '0);
    check("rst_w_data", bus.w_data_o,   '0);
    check("rst_stall", bus.wb_stall_o,  1'b0);
    check("rst_busy1", bus.busy1_o,     1'b0);
    check("rst_busy2", bus.busy2_o,     1'b0);
    check("rst_ready", bus.lsu_ready_o, 1'b0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", bus.lsu_ready_o, 1'b1);

    // ALU result lands one cycle later
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd5; bus.alu_data_i = 32'hDEADBEEF;
    exp_write(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("alu_w_en",   bus.w_en_o,   1'b1);
    check("alu_w_addr", bus.w_addr_o, 5'd5);
    check("alu_w_data", bus.w_data_o, 32'hDEADBEEF);
    bus.alu_valid_i = 1'b0;
    @(negedge clk);
    check("idle_w_en",     bus.w_en_o,   1'b0);
    check("hold_w_addr",   bus.w_addr_o, 5'd5);
    check("hold_w_data",   bus.w_data_o, 32'hDEADBEEF);

    // issue rd=7, then its LSU result clears pending at pop
    bus.issue_en_i = 1'b1; bus.issue_rd_i = 5'd7;
    bus.chk_addr1_i = 5'd7; bus.chk_addr2_i = 5'd7;
    @(negedge clk);
    bus.issue_en_i = 1'b0;
    check("pend7_busy1", bus.busy1_o, 1'b1);
    check("pend7_busy2", bus.busy2_o, 1'b1);
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd7; bus.lsu_data_i = 32'h1234;
    exp_write(5'd7, 32'h1234);
    @(negedge clk);
    bus.lsu_valid_i = 1'b0;
    check("pend7_busy_queued", bus.busy1_o,    1'b1);
    check("lsu_no_bypass",     bus.w_en_o,     1'b0);
    check("ready_one_entry",   bus.lsu_ready_o, 1'b1);
    @(negedge clk);
    check("lsu_w_en",     bus.w_en_o,  1'b1);
    check("pend7_clear1", bus.busy1_o, 1'b0);
    check("pend7_clear2", bus.busy2_o, 1'b0);
    bus.chk_addr1_i = '0; bus.chk_addr2_i = '0;

    // ALU every cycle: FIFO fills, third LSU result waits, starvation stall
    da = $urandom; db = $urandom; dc = $urandom;
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'(10 + i); bus.alu_data_i = d;
      exp_write(5'(10 + i), d);
      bus.lsu_valid_i = 1'b1;
      if (i == 0)      begin bus.lsu_rd_i = 5'd20; bus.lsu_data_i = da; end
      else if (i == 1) begin bus.lsu_rd_i = 5'd21; bus.lsu_data_i = db; end
      else             begin bus.lsu_rd_i = 5'd22; bus.lsu_data_i = dc; end
      check("fill_ready", bus.lsu_ready_o, (i < 2) ? 1'b1 : 1'b0);
      check("no_early_stall", bus.wb_stall_o, 1'b0);
      @(negedge clk);
    end
    check("starve_stall", bus.wb_stall_o,  1'b1);
    check("full_ready",   bus.lsu_ready_o, 1'b0);
    bus.alu_valid_i = 1'b0;
    exp_write(5'd20, da);
    exp_write(5'd21, db);
    exp_write(5'd22, dc);
    @(negedge clk);
    check("stall_drop",      bus.wb_stall_o,  1'b0);
    check("stall_pop_w_en",  bus.w_en_o,      1'b1);
    check("ready_after_pop", bus.lsu_ready_o, 1'b1);
    @(negedge clk);
    bus.lsu_valid_i = 1'b0;
    check("no_restall", bus.wb_stall_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("drain_idle", bus.w_en_o,      1'b0);
    check("drain_ready", bus.lsu_ready_o, 1'b1);

    // x0: ALU rd=0 lets FIFO pop; LSU rd=0 popped silently; issue rd=0 ignored
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd9; bus.lsu_data_i = 32'h0000_0D09;
    exp_write(5'd9, 32'h0000_0D09);
    @(negedge clk);
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = '0; bus.alu_data_i = 32'hFFFF_FFFF;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = '0; bus.lsu_data_i = 32'h5555_5555;
    bus.issue_en_i  = 1'b1; bus.issue_rd_i = '0;
    @(negedge clk);
    bus.alu_valid_i = 1'b0; bus.lsu_valid_i = 1'b0; bus.issue_en_i = 1'b0;
    check("x0_alu_yields", bus.w_en_o,   1'b1);
    check("x0_pop_addr",   bus.w_addr_o, 5'd9);
    check("x0_busy",       bus.busy1_o,  1'b0);
    @(negedge clk);
    check("x0_lsu_no_w_en", bus.w_en_o,      1'b0);
    check("x0_hold_addr",   bus.w_addr_o,    5'd9);
    check("x0_ready",       bus.lsu_ready_o, 1'b1);

    // reset with two FIFO entries and rd=3 pending
    bus.issue_en_i = 1'b1; bus.issue_rd_i = 5'd3; bus.chk_addr1_i = 5'd3;
    @(negedge clk);
    bus.issue_en_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'(12 + i); bus.alu_data_i = d;
      exp_write(5'(12 + i), d);
      bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'(3 + i); bus.lsu_data_i = $urandom;
      @(negedge clk);
    end
    check("pre_rst_full", bus.lsu_ready_o, 1'b0);
    check("pre_rst_busy", bus.busy1_o,     1'b1);
    #2;
    rst = 1'b1;
    bus.alu_valid_i = 1'b0; bus.lsu_valid_i = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_w_en",   bus.w_en_o,      1'b0);
    check("mid_rst_w_addr", bus.w_addr_o,    '0);
    check("mid_rst_w_data", bus.w_data_o,    '0);
    check("mid_rst_stall",  bus.wb_stall_o,  1'b0);
    check("mid_rst_busy",   bus.busy1_o,     1'b0);
    check("mid_rst_ready",  bus.lsu_ready_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", bus.lsu_ready_o, 1'b1);
    check("post_rst_busy",  bus.busy1_o,     1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_write", bus.w_en_o, 1'b0);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
